// File: rtl/dotstar_pkg.sv
// dotstar_pkg
//   Shared definitions for the APA102/DotStar strip driver: FSM state codes,
//   frame constants, pixel colour layout and frame-size helpers.
package dotstar_pkg;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_PIXEL = 2'd2;
   localparam logic [1:0] ST_END   = 2'd3;

   localparam logic [31:0] START_WORD = 32'h0;
   localparam logic [2:0]  PIXEL_HDR  = 3'b111;

   // Host-side colour layout {R, G, B}
   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // End frame needs one extra clock edge per two pixels to flush the strip
   function automatic int end_bytes(input int n);
      return (n + 15) / 16;
   endfunction

   function automatic int bits_per_frame(input int n);
      return 32 + 32 * n + 8 * end_bytes(n);
   endfunction

   // On-wire pixel word: header, brightness, then B, G, R
   function automatic logic [31:0] pixel_word(input logic [4:0] bri, input rgb_t c);
      return {PIXEL_HDR, bri, c.b, c.g, c.r};
   endfunction

endpackage

// File: rtl/dotstar_pixel_ram.sv
// dotstar_pixel_ram
//   DEPTH x 24-bit simple dual-port frame buffer. Synchronous write,
//   registered read (1-cycle latency, read-before-write on same address).
//   No reset: pixel contents survive a driver reset.
// Ports:
//   i_clk      clock
//   i_wr_en    write strobe; out-of-range addresses are dropped
//   i_wr_addr  write pixel index
//   i_wr_data  colour to store
//   i_rd_en    read strobe; output holds last read otherwise
//   i_rd_addr  read pixel index
//   o_rd_data  registered read data
module dotstar_pixel_ram
   import dotstar_pkg::*;
#(
   parameter int DEPTH  = 60,
   parameter int ADDR_W = 6
) (
   input  logic              i_clk,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  rgb_t              i_wr_data,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output rgb_t              o_rd_data
);

   rgb_t r_mem [DEPTH];
   rgb_t r_rd_data;

   always_ff @(posedge i_clk) begin
      if (i_wr_en && (32'(i_wr_addr) < DEPTH))
         r_mem[i_wr_addr] <= i_wr_data;
      if (i_rd_en && (32'(i_rd_addr) < DEPTH))
         r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dotstar_strip_driver.sv
// dotstar_strip_driver
//   Serialises one APA102 frame (start word, NUM_PIXELS pixel words,
//   end frame of ones) onto o_mosi/o_sck on each accepted start request.
//   SCK is a continuous square wave of period 2*CLK_DIV for the whole frame.
// Ports:
//   i_dotstar_clk    clock, rising edge
//   i_dotstar_reset  synchronous active-low reset
//   i_wr_en/addr/data  host pixel write port (accepted any time)
//   i_brightness     5-bit global brightness, latched at frame start
//   i_start          single-cycle frame request (ignored unless idle)
//   o_busy           high while a frame is being shifted
//   o_frame_done     one-cycle pulse after the final bit
//   o_mosi           serial data, MSB first, changes only while sck low
//   o_sck            serial clock, idle low
module dotstar_strip_driver
   import dotstar_pkg::*;
#(
   parameter int NUM_PIXELS = 60,
   parameter int CLK_DIV    = 4,
   localparam int ADDR_W    = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
   input  logic              i_dotstar_clk,
   input  logic              i_dotstar_reset,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [23:0]       i_wr_data,
   input  logic [4:0]        i_brightness,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_frame_done,
   output logic              o_mosi,
   output logic              o_sck
);

   localparam int              PH_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PH_W-1:0] PH_LAST  = PH_W'(CLK_DIV - 1);
   // Second-to-last cycle of a bit when the high phase spans >1 cycle
   localparam logic [PH_W-1:0] PH_PRE   = PH_W'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);
   localparam int              END_BITS = 8 * end_bytes(NUM_PIXELS);
   localparam logic [9:0]      END_LAST = 10'(END_BITS - 1);
   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

   logic [1:0]        r_state;
   logic [PH_W-1:0]   r_phase;
   logic              r_sck;
   logic [31:0]       r_shift;
   logic [9:0]        r_bit_cnt;
   logic [ADDR_W-1:0] r_pix_idx;
   logic [4:0]        r_bri;
   logic              r_frame_done;

   logic              w_word_last;
   logic              w_fetch_slot;
   logic              w_rd_en;
   logic [ADDR_W-1:0] w_rd_addr;
   rgb_t              w_rd_data;
   logic [31:0]       w_pix_word;
   logic              w_start_ok;

   assign w_word_last = (r_bit_cnt == 10'd31);

   // The RAM read must land on the cycle before the bit-ending edge so the
   // registered data is ready when the next word loads. With CLK_DIV=1 the
   // high phase is a single cycle, so that slot is the low phase instead.
   assign w_fetch_slot = (CLK_DIV == 1) ? !r_sck : (r_sck && (r_phase == PH_PRE));

   assign w_rd_en = w_fetch_slot && w_word_last &&
                    ((r_state == ST_START) ||
                     ((r_state == ST_PIXEL) && (r_pix_idx != LAST_PIX)));

   assign w_rd_addr = (r_state == ST_START) ? '0 : r_pix_idx + ADDR_W'(1);

   assign w_pix_word = pixel_word(r_bri, w_rd_data);

   // The frame_done cycle is still treated as busy for new requests
   assign w_start_ok = i_start && (r_state == ST_IDLE) && !r_frame_done;

   dotstar_pixel_ram #(
      .DEPTH  (NUM_PIXELS),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .i_clk     (i_dotstar_clk),
      .i_wr_en   (i_wr_en),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (rgb_t'(i_wr_data)),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd_data)
   );

   always_ff @(posedge i_dotstar_clk) begin
      if (!i_dotstar_reset) begin
         r_state      <= ST_IDLE;
         r_phase      <= '0;
         r_sck        <= 1'b0;
         r_shift      <= '0;
         r_bit_cnt    <= '0;
         r_pix_idx    <= '0;
         r_bri        <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (r_state == ST_IDLE) begin
            if (w_start_ok) begin
               r_state   <= ST_START;
               r_bri     <= i_brightness;
               r_shift   <= START_WORD;
               r_bit_cnt <= '0;
               r_pix_idx <= '0;
               r_phase   <= '0;
               r_sck     <= 1'b0;
            end
         end else if (r_phase != PH_LAST) begin
            r_phase <= r_phase + PH_W'(1);
         end else begin
            r_phase <= '0;
            r_sck   <= !r_sck;
            // Bit boundary: end of the high phase, next bit goes out as sck falls
            if (r_sck) begin
               r_bit_cnt <= r_bit_cnt + 10'd1;
               r_shift   <= {r_shift[30:0], (r_state == ST_END)};
               case (r_state)
                  ST_START: begin
                     if (w_word_last) begin
                        r_state   <= ST_PIXEL;
                        r_pix_idx <= '0;
                        r_shift   <= w_pix_word;
                        r_bit_cnt <= '0;
                     end
                  end
                  ST_PIXEL: begin
                     if (w_word_last) begin
                        r_bit_cnt <= '0;
                        if (r_pix_idx == LAST_PIX) begin
                           r_state <= ST_END;
                           r_shift <= '1;
                        end else begin
                           r_pix_idx <= r_pix_idx + ADDR_W'(1);
                           r_shift   <= w_pix_word;
                        end
                     end
                  end
                  ST_END: begin
                     if (r_bit_cnt == END_LAST) begin
                        r_state      <= ST_IDLE;
                        r_shift      <= '0;
                        r_bit_cnt    <= '0;
                        r_frame_done <= 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign o_busy       = (r_state != ST_IDLE);
   assign o_frame_done = r_frame_done;
   assign o_mosi       = r_shift[31];
   assign o_sck        = r_sck;

endmodule

// File: doc/dotstar_strip_driver.md
# dotstar_strip_driver

Parametrised APA102/DotStar LED-strip driver: holds a frame buffer of NUM_PIXELS 24-bit colours and, on request, serialises one complete strip frame (start frame, per-pixel words, end frame) onto mosi/sck. It generalises the fixed-pattern dostring wave generator to any strip length, any SCK rate, per-frame global brightness and host-writable pixel data. It sits under top, fed by board clock CLK and reset my_reset.

## Interface
- NUM_PIXELS, 60: pixels in the strip, 1..1024.
- CLK_DIV, 4: SCK half-period in clock cycles, ≥1; bit period = 2*CLK_DIV cycles.
- dotstar_clk  in  1  sole clock; all logic on rising edge.
- dotstar_reset  in  1  synchronous, active-low reset.
- wr_en  in  1  pixel write strobe.
- wr_addr  in  $clog2(NUM_PIXELS)  pixel index.
- wr_data  in  24  colour {R[23:16], G[15:8], B[7:0]}.
- brightness  in  5  global brightness, sampled at frame start.
- start  in  1  single-cycle frame request.
- busy  out  1  high while a frame is being shifted.
- frame_done  out  1  one-cycle pulse at end of frame.
- mosi  out  1  serial data, MSB first.
- sck  out  1  serial clock, idle low.

## Operation
- States: IDLE, START_FRAME, PIXEL, END_FRAME.
- IDLE: sck=0, mosi=0, busy=0. start=1 → latch brightness, load shift register with 32'h0, go START_FRAME, busy=1 next cycle.
- START_FRAME: 32 zero bits → PIXEL, pixel index 0.
- PIXEL: word = {3'b111, brightness_latched, B, G, R}, 32 bits; after last bit of pixel NUM_PIXELS-1 → END_FRAME, else next index.
- END_FRAME: END_BYTES*8 one bits, END_BYTES = (NUM_PIXELS+15)/16 → IDLE, frame_done=1 one cycle, busy=0 same cycle.
- Total bits per frame = 32 + 32*NUM_PIXELS + 8*END_BYTES.
- start while busy: ignored, no queueing. start in the frame_done cycle: ignored; accepted from the following cycle.
- Writes accepted at any time, including while busy; wr_addr ≥ NUM_PIXELS ignored.
- Pixel fetched from buffer during last bit of preceding word; write to a pixel not yet fetched appears in current frame. Write and fetch of same address in same cycle: fetch returns old data.
- Reset: state IDLE, sck=0, mosi=0, busy=0, frame_done=0, bit/pixel counters 0 on the first clock with dotstar_reset=0, including mid-frame. Frame buffer is not cleared by reset.

## Timing
- mosi changes only while sck low; strip samples on sck rising edge.
- Per bit: mosi valid on entry to low phase; sck low CLK_DIV cycles, high CLK_DIV cycles.
- First bit: busy and mosi (bit 31 of start frame) valid the cycle after start; first sck rise CLK_DIV cycles later.
- Frame length from start to frame_done = 1 + total_bits*2*CLK_DIV cycles; frame_done coincides with the first low cycle after the final high phase.
- Pixel buffer read latency 1 cycle (synchronous RAM); fetch issued so word is loaded without gap between words.
- No bubble between sections; sck is a continuous square wave for the whole frame.

## Structure
- Package dotstar_pkg: state encoding, START_WORD=32'h0, PIXEL_HDR=3'b111, function end_bytes(n)=(n+15)/16, bits_per_frame(n).
- Sub-module dotstar_pixel_ram: NUM_PIXELS×24 simple dual-port RAM, synchronous write, registered read, no reset.
- Top of block: FSM, 32-bit shift register, CLK_DIV phase counter, bit counter (0..31 / end-frame), pixel index.

## Test plan
- NUM_PIXELS=2, CLK_DIV=2; write px0=24'hFF0000, px1=24'h123456, brightness=5'h1F then 5'h03 per frame; start → 104 sck rises; captured bits = 32'h0, 32'hFF0000FF, 32'hFF563412, 8'hFF; frame_done 417 cycles after start.
- Same, brightness=5'h03 → pixel words 32'hE30000FF, 32'hE3563412.
- start pulsed again at cycles 10 and 200 of a frame → ignored; exactly one frame; busy drops with frame_done.
- Write px1=24'h00FF00 during start-frame phase → frame carries 32'hFF00FF00 for px1; write px0 during px1 → not visible until next frame.
- dotstar_reset low at cycle 150 mid-frame → next cycle sck=0, mosi=0, busy=0; new start after reset emits full frame with pre-reset buffer contents.
- NUM_PIXELS=17, CLK_DIV=1 → END_BYTES=2, 32+544+16=592 bits, frame_done 1185 cycles after start; wr_addr=17 write ignored.
